bsh_32_unit: RTL and testbench

- 32-bit logarithmic barrel shifter with a registered output, used as a datapath shift unit.
- Performs a logical shift (zero fill) of a 32-bit word, left or right, by 0..31 bit positions, selected per transaction.
- Implemented as five cascaded 2:1 mux stages (shift by 1, 2, 4, 8, 16), followed by one output register stage with a valid flag.

---
 rtl/bsh_32_unit.sv | 62 ++++++
 tb/tb_bsh_32_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bsh_32_unit.sv
// rtl/bsh_32_unit.sv - 32-bit logarithmic logical barrel shifter with registered output
module bsh_32_unit #(
  parameter int WIDTH = 32,
  parameter int SH_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  input  logic [SH_W-1:0]  sh,
  input  logic             in_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid
);

  // stage_w[0] is the operand; stage_w[k+1] is the output of the shift-by-2^k mux level
  logic [WIDTH-1:0] stage_w [SH_W+1];

  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;

  // Five cascaded 2:1 mux levels; direction is applied identically in every level
  always_comb begin
    stage_w[0] = data_in;
    for (int k = 0; k < SH_W; k++) begin
      if (sh[k]) begin
        if (dir) begin
          stage_w[k+1] = stage_w[k] >> (1 << k);
        end else begin
          stage_w[k+1] = stage_w[k] << (1 << k);
        end
      end else begin
        stage_w[k+1] = stage_w[k];
      end
    end
  end

  // Next-state: capture a new result only for a qualified input, otherwise hold the data.
  // out_valid depends on in_valid alone so garbage operands in idle cycles cannot leak into it.
  always_comb begin
    out_valid_d = in_valid;
    data_out_d  = data_out_q;
    if (in_valid) begin
      data_out_d = stage_w[SH_W];
    end
  end

  // Output register stage; reset clears it immediately, independent of the clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bsh_32_unit.sv
// tb/tb_bsh_32_unit.sv - randomized self-checking bench for bsh_32_unit
module tb_bsh_32_unit;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic        dir;
  logic [4:0]  sh;
  logic        in_valid;
  logic [31:0] data_out;
  logic        out_valid;

  int n_cmp;
  int n_bad;

  logic [31:0] held;

  bsh_32_unit dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .dir       (dir),
    .sh        (sh),
    .in_valid  (in_valid),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1);
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic r, input int s);
    longint unsigned wide;
    wide = {32'h0, d};
    if (r) wide = wide >> s;
    else   wide = (wide << s) & 64'h0000_0000_FFFF_FFFF;
    return wide[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, need %08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, then sample 1 time unit after the next rising edge
  task automatic cycle(input logic [31:0] d, input logic r, input logic [4:0] s, input logic v);
    @(negedge clk);
    data_in  = d;
    dir      = r;
    sh       = s;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string tag, input logic [31:0] d, input logic r, input logic [4:0] s,
                     input logic [31:0] exp);
    cycle(d, r, s, 1'b1);
    check({tag, "_data"}, data_out, exp);
    check({tag, "_vld"}, {31'h0, out_valid}, 32'h1);
    held = exp;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    held = 32'h0;
    rst = 1'b1;
    data_in = 32'h0;
    dir = 1'b0;
    sh = 5'd0;
    in_valid = 1'b0;

    #1;
    check("rst_data", data_out, 32'h0);
    check("rst_vld", {31'h0, out_valid}, 32'h0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the behavioural rules
    txn("left10",  32'h18A00000, 1'b0, 5'd10, 32'h80000000);
    txn("right20", 32'h00FF0003, 1'b1, 5'd20, 32'h0000000F);
    txn("sh0_l",   32'hDEADBEEF, 1'b0, 5'd0,  32'hDEADBEEF);
    txn("sh0_r",   32'hDEADBEEF, 1'b1, 5'd0,  32'hDEADBEEF);
    txn("l31",     32'h00000001, 1'b0, 5'd31, 32'h80000000);
    txn("r31",     32'h80000000, 1'b1, 5'd31, 32'h00000001);
    txn("r1_nosx", 32'h80000000, 1'b1, 5'd1,  32'h40000000);
    txn("l31_all", 32'hFFFFFFFF, 1'b0, 5'd31, 32'h80000000);
    txn("r31_all", 32'hFFFFFFFF, 1'b1, 5'd31, 32'h00000001);

    // Throughput: three back-to-back transactions then an idle cycle
    cycle(32'h0, 1'b0, 5'd0, 1'b0);
    txn("tp0", 32'h18A00000, 1'b0, 5'd10, 32'h80000000);
    txn("tp1", 32'h00FF0003, 1'b1, 5'd20, 32'h0000000F);
    txn("tp2", 32'hDEADBEEF, 1'b0, 5'd0,  32'hDEADBEEF);
    cycle(32'h12345678, 1'b1, 5'd3, 1'b0);
    check("tp_idle_vld", {31'h0, out_valid}, 32'h0);
    check("tp_idle_hold", data_out, 32'hDEADBEEF);

    // Sweep every shift amount in both directions with random operands
    for (int rep = 0; rep < 3; rep++) begin
      for (int d = 0; d < 2; d++) begin
        for (int s = 0; s < 32; s++) begin
          logic [31:0] v;
          v = $urandom;
          txn("sweep", v, d[0], s[4:0], ref_shift(v, d[0], s));
        end
      end
    end

    // Random valid/idle mix: idle cycles must drop out_valid and hold the last result
    for (int i = 0; i < 400; i++) begin
      logic [31:0] v;
      logic        r;
      logic [4:0]  s;
      logic        vl;
      v  = $urandom;
      r  = 1'($urandom_range(0, 1));
      s  = 5'($urandom_range(0, 31));
      vl = ($urandom_range(0, 3) != 0);
      cycle(v, r, s, vl);
      if (vl) held = ref_shift(v, r, int'(s));
      check("mix_data", data_out, held);
      check("mix_vld", {31'h0, out_valid}, {31'h0, vl});
    end

    // Asynchronous reset in mid-cycle with a valid transaction pending
    txn("pre_rst", 32'h0000FFFF, 1'b0, 5'd4, 32'h000FFFF0);
    @(negedge clk);
    data_in  = 32'hCAFEF00D;
    dir      = 1'b0;
    sh       = 5'd1;
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_data", data_out, 32'h0);
    check("arst_vld", {31'h0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    check("arst_edge_data", data_out, 32'h0);
    check("arst_edge_vld", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_data", data_out, 32'h0);
    check("post_rst_vld", {31'h0, out_valid}, 32'h0);

    // First transaction after reset release
    txn("post_rst_txn", 32'h00000003, 1'b0, 5'd30, 32'hC0000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
